// File: rtl/rst_seq_ctrl_if.sv
// rtl/rst_seq_ctrl_if.sv - software reset request and staggered channel reset bundle
interface rst_seq_ctrl_if #(
    parameter int NUM_CH = 4
);
    logic              sw_rst_req;
    logic [NUM_CH-1:0] ch_rst_n;
    logic              rst_done;

    modport master (
        input  sw_rst_req,
        output ch_rst_n,
        output rst_done
    );

    modport slave (
        output sw_rst_req,
        input  ch_rst_n,
        input  rst_done
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - multi-channel reset sequencer with synchronised release and stagger
module rst_seq_ctrl #(
    parameter int NUM_STAGES = 2,
    parameter int NUM_CH     = 4,
    parameter int MIN_ASSERT = 16,
    parameter int STAGGER    = 8
) (
    input  logic             clk,
    input  logic             rst,
    rst_seq_ctrl_if.master   bus
);
    localparam int CMAX = (MIN_ASSERT > STAGGER) ? MIN_ASSERT : STAGGER;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(NUM_CH + 1);
    localparam int SW   = NUM_STAGES - 1;

    localparam logic [CW-1:0]     HOLD_LAST = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0]     STAG_LAST = CW'(STAGGER - 1);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(NUM_CH - 1);
    localparam logic [SW-1:0]     SYNC_ONE  = SW'(1);
    localparam logic [NUM_CH-1:0] CH_ONE    = NUM_CH'(1);

    typedef enum logic [1:0] {SYNC, HOLD, REL, DONE} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     sync;
    logic              sync_ok;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [NUM_CH-1:0] ch_q, ch_nxt;
    logic              done_q, done_nxt;

    // The state register is the last synchroniser stage: leaving SYNC
    // happens on the edge where the deassertion reaches stage NUM_STAGES.
    assign sync_ok = sync[SW-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync   <= '0;
            state  <= SYNC;
            cnt    <= '0;
            idx    <= '0;
            ch_q   <= '0;
            done_q <= 1'b0;
        end else begin
            sync   <= (sync << 1) | SYNC_ONE;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            ch_q   <= ch_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        ch_nxt    = ch_q;
        done_nxt  = done_q;

        case (state)
            SYNC: begin
                if (sync_ok) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    ch_nxt    = ch_q | CH_ONE;
                    cnt_nxt   = '0;
                    idx_nxt   = IW'(1);
                    if (NUM_CH == 1) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = REL;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            REL: begin
                if (cnt == STAG_LAST) begin
                    ch_nxt  = ch_q | (CH_ONE << idx);
                    cnt_nxt = '0;
                    idx_nxt = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
            end
            default: state_nxt = SYNC;
        endcase

        // A software request restarts the hold window; ignored until synchronised.
        if (state != SYNC && bus.sw_rst_req) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            ch_nxt    = '0;
            done_nxt  = 1'b0;
        end
    end

    assign bus.ch_rst_n = ch_q;
    assign bus.rst_done = done_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - directed bench for rst_seq_ctrl (default and minimal parameter sets)
module tb_rst_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rst_seq_ctrl_if #(.NUM_CH(4)) bus ();
    rst_seq_ctrl_if #(.NUM_CH(1)) sbus ();

    rst_seq_ctrl #(
        .NUM_STAGES(2), .NUM_CH(4), .MIN_ASSERT(16), .STAGGER(8)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    rst_seq_ctrl #(
        .NUM_STAGES(3), .NUM_CH(1), .MIN_ASSERT(1), .STAGGER(1)
    ) dut_s (
        .clk(clk), .rst(rst), .bus(sbus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // edge (counted from rst release), expected ch_rst_n, expected rst_done
    int   tbl_e    [10] = '{17, 18, 25, 26, 30, 33, 34, 41, 42, 45};
    logic [3:0] tbl_ch [10] = '{4'b0000, 4'b0001, 4'b0001, 4'b0011, 4'b0011,
                                4'b0011, 4'b0111, 4'b0111, 4'b1111, 4'b1111};
    logic tbl_done [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_ch"},    32'(bus.ch_rst_n),  32'h0);
        check({tag, "_done"},  32'(bus.rst_done),  32'h0);
        check({tag, "_sch"},   32'(sbus.ch_rst_n), 32'h0);
        check({tag, "_sdone"}, 32'(sbus.rst_done), 32'h0);
    endtask

    // Steps n edges; sw_at > 0 pulses sw_rst_req sampled at that edge and
    // shifts the release table so ch0 is expected 16 edges after it.
    task automatic run_seq(input int n, input int sw_at, input bit chk_sweep);
        int off;
        off = (sw_at == 0) ? 0 : 2 - sw_at;
        for (int e = 1; e <= n; e++) begin
            bus.sw_rst_req  = (e == sw_at);
            sbus.sw_rst_req = chk_sweep && (e == 2);
            @(posedge clk);
            #1;
            bus.sw_rst_req  = 1'b0;
            sbus.sw_rst_req = 1'b0;
            if (e == sw_at) begin
                check($sformatf("sw_clr_ch@%0d", e),   32'(bus.ch_rst_n), 32'h0);
                check($sformatf("sw_clr_done@%0d", e), 32'(bus.rst_done), 32'h0);
            end
            for (int i = 0; i < 10; i++) begin
                if (e + off == tbl_e[i]) begin
                    check($sformatf("ch@%0d", e),   32'(bus.ch_rst_n), 32'(tbl_ch[i]));
                    check($sformatf("done@%0d", e), 32'(bus.rst_done), 32'(tbl_done[i]));
                end
            end
            if (chk_sweep && e == 3) begin
                check("sweep_ch@3",   32'(sbus.ch_rst_n), 32'h0);
                check("sweep_done@3", 32'(sbus.rst_done), 32'h0);
            end
            if (chk_sweep && e == 4) begin
                check("sweep_ch@4",   32'(sbus.ch_rst_n), 32'h1);
                check("sweep_done@4", 32'(sbus.rst_done), 32'h1);
            end
        end
    endtask

    initial begin
        bus.sw_rst_req  = 1'b0;
        sbus.sw_rst_req = 1'b0;
        rst = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check_all_reset("por");

        // power-on sequence; sweep instance gets a request during SYNC
        @(negedge clk);
        rst = 1'b1;
        run_seq(45, 0, 1'b1);

        // async assertion from DONE, visible before any clock edge
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_reset("async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_seq(45, 0, 1'b1);

        // reset dropped mid-release at edge 30
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_seq(30, 0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_all_reset("midrel");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_seq(45, 0, 1'b0);

        // software request in DONE
        run_seq(44, 1, 1'b0);

        // short glitch on rst in DONE is a full reset
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_reset("glitch");
        run_seq(45, 0, 1'b0);

        // software request at HOLD cycle 10 (edge 12) restarts the hold
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_seq(55, 12, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
